iw_sequencer: RTL and testbench

Parametrised multi-cycle executor for the wide-immediate move class: MOVZ, MOVN and MOVK.
- Decodes one 32-bit instruction word per transaction.
- Builds the shifted immediate K for any halfword position of a DATA_WIDTH register.
- Performs MOVK as a read-modify-write through register-file port A.
- Sits beside the control unit: the control unit hands it a wide-immediate instruction via start and resumes on done.

---
 rtl/iw_sequencer.sv | 135 +++++++++++++
 tb/tb_iw_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iw_sequencer.sv
// Multi-cycle executor for the wide-immediate moves MOVZ / MOVN / MOVK.
// MOVK does a read-modify-write of Rd through register-file port A.
module iw_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int IMM_WIDTH  = 16,
    parameter int HW_BITS    = 2,
    parameter int RA_WIDTH   = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic [RA_WIDTH-1:0]   rf_sel_a,
    output logic [RA_WIDTH-1:0]   rf_waddr,
    output logic                  rf_we,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [DATA_WIDTH-1:0] k_out
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | MOVK only: Rd on port A, old value captured into hold
    // WRITE | result on write port, done pulses
    // FAULT | rejected instruction, done + illegal, no write
    typedef enum logic [1:0] {IDLE, READ, WRITE, FAULT} state_t;

    localparam logic [RA_WIDTH-1:0]   ZR_ADDR = '1;
    localparam int                    NUM_HW  = DATA_WIDTH / IMM_WIDTH;
    localparam logic [DATA_WIDTH-1:0] W_MASK  = DATA_WIDTH'(32'hFFFF_FFFF);

    state_t                state;
    logic [31:0]           instr_q;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] k_q;
    logic [DATA_WIDTH-1:0] hw_mask;
    logic [DATA_WIDTH-1:0] result;

    function automatic int shift_of(input logic [31:0] w);
        return int'(w[21 +: HW_BITS]) * IMM_WIDTH;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] k_of(input logic [31:0] w);
        return DATA_WIDTH'(w[5 +: IMM_WIDTH]) << shift_of(w);
    endfunction

    function automatic logic is_illegal(input logic [31:0] w);
        int hw;
        hw = int'(w[21 +: HW_BITS]);
        return (w[28:23] != 6'b100101) || (w[30:29] == 2'b01) ||
               (hw > NUM_HW - 1) || (!w[31] && hw >= 2);
    endfunction

    function automatic logic is_movk(input logic [31:0] w);
        return w[30:29] == 2'b11;
    endfunction

    function automatic logic [RA_WIDTH-1:0] rd_of(input logic [31:0] w);
        return w[0 +: RA_WIDTH];
    endfunction

    // Write data is a pure function of the latched word and hold, so it is
    // already stable when WRITE is entered from either IDLE or READ.
    always_comb begin
        k_q     = k_of(instr_q);
        hw_mask = DATA_WIDTH'({IMM_WIDTH{1'b1}}) << shift_of(instr_q);
        case (instr_q[30:29])
            2'b00:   result = ~k_q;
            2'b11:   result = (hold & ~hw_mask) | k_q;
            default: result = k_q;
        endcase
        if (!instr_q[31])
            result = result & W_MASK;
        rf_wdata = (state == WRITE) ? result : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            instr_q  <= '0;
            hold     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            rf_sel_a <= '0;
            rf_waddr <= '0;
            rf_we    <= 1'b0;
            k_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        instr_q <= instr;
                        k_out   <= k_of(instr);
                        busy    <= 1'b1;
                        if (is_illegal(instr)) begin
                            state   <= FAULT;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                        end else if (is_movk(instr)) begin
                            state    <= READ;
                            rf_sel_a <= rd_of(instr);
                        end else begin
                            state    <= WRITE;
                            done     <= 1'b1;
                            rf_waddr <= rd_of(instr);
                            rf_we    <= (rd_of(instr) != ZR_ADDR);
                        end
                    end
                end
                READ: begin
                    state    <= WRITE;
                    hold     <= rf_rdata;
                    rf_sel_a <= '0;
                    done     <= 1'b1;
                    rf_waddr <= rd_of(instr_q);
                    rf_we    <= (rd_of(instr_q) != ZR_ADDR);
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    illegal  <= 1'b0;
                    rf_waddr <= '0;
                    rf_we    <= 1'b0;
                    k_out    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iw_sequencer.sv
// Bench for iw_sequencer: directed cases plus randomized words against a
// halfword-level reference model and a bench-owned register file.
module tb_iw_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] instr;
    logic [63:0] rf_rdata;
    logic        busy, done, illegal, rf_we;
    logic [4:0]  rf_sel_a, rf_waddr;
    logic [63:0] rf_wdata, k_out;

    logic [63:0] regs [32];
    int checks = 0;
    int errors = 0;

    assign rf_rdata = regs[rf_sel_a];

    iw_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .instr(instr),
        .rf_rdata(rf_rdata), .busy(busy), .done(done), .illegal(illegal),
        .rf_sel_a(rf_sel_a), .rf_waddr(rf_waddr), .rf_we(rf_we),
        .rf_wdata(rf_wdata), .k_out(k_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void model(input logic [31:0] w, input logic [63:0] old,
                                  output bit ill, output bit movk,
                                  output logic [63:0] k, output logic [63:0] res);
        logic [1:0]  opc;
        logic [15:0] imm;
        int          hw;
        opc  = w[30:29];
        imm  = w[20:5];
        hw   = int'(w[22:21]);
        ill  = (w[28:23] != 6'b100101) || (opc == 2'b01) || (!w[31] && hw >= 2);
        movk = (opc == 2'b11);
        k    = 64'h0;
        k[16*hw +: 16] = imm;
        case (opc)
            2'b10:   res = k;
            2'b00:   res = ~k;
            2'b11: begin
                res = old;
                res[16*hw +: 16] = imm;
            end
            default: res = 64'h0;
        endcase
        if (!w[31]) res[63:32] = 32'h0;
    endfunction

    // Present a word for exactly one rising edge; returns just after edge T.
    task automatic issue(input logic [31:0] w);
        @(negedge clock);
        start = 1'b1;
        instr = w;
        @(posedge clock);
        #1;
        start = 1'b0;
        instr = $urandom;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, illegal, rf_we, rf_sel_a, rf_waddr} !== 14'h0 ||
            rf_wdata !== 64'h0 || k_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b ill=%b we=%b wd=%h k=%h exp all zero",
                     busy, done, illegal, rf_we, rf_wdata, k_out);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done, rf_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b we=%b exp 000", busy, done, rf_we);
        end
    endtask

    task automatic test_movz();
        issue({9'b110100101, 2'b01, 16'h1234, 5'd3});
        @(negedge clock);
        checks++;
        if ({busy, done, illegal, rf_we, rf_waddr} !== {4'b1101, 5'd3} ||
            rf_wdata !== 64'h0000_0000_1234_0000) begin
            errors++;
            $display("FAIL movz_write got ctl=%b addr=%0d wd=%h exp ctl=1101 addr=3 wd=0000000012340000",
                     {busy, done, illegal, rf_we}, rf_waddr, rf_wdata);
        end
        checks++;
        if (k_out !== 64'h0000_0000_1234_0000) begin
            errors++;
            $display("FAIL movz_k got %h exp 0000000012340000", k_out);
        end
        @(negedge clock);
        checks++;
        if ({busy, done, rf_we} !== 3'b000 || rf_wdata !== 64'h0) begin
            errors++;
            $display("FAIL movz_idle got busy=%b done=%b we=%b wd=%h exp 0", busy, done, rf_we, rf_wdata);
        end
    endtask

    task automatic test_movk();
        regs[5] = 64'h1111_2222_3333_4444;
        issue({9'b111100101, 2'b11, 16'hBEEF, 5'd5});
        @(negedge clock);
        checks++;
        if ({busy, done, rf_we} !== 3'b100 || rf_sel_a !== 5'd5) begin
            errors++;
            $display("FAIL movk_read got busy=%b done=%b we=%b sel=%0d exp 100 sel=5",
                     busy, done, rf_we, rf_sel_a);
        end
        @(negedge clock);
        regs[5] = 64'h0;
        checks++;
        if ({busy, done, rf_we, rf_waddr} !== {3'b111, 5'd5} || rf_wdata !== 64'hBEEF_2222_3333_4444) begin
            errors++;
            $display("FAIL movk_write got ctl=%b addr=%0d wd=%h exp ctl=111 addr=5 wd=beef222233334444",
                     {busy, done, rf_we}, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_movn();
        issue({9'b100100101, 2'b00, 16'h0000, 5'd1});
        @(negedge clock);
        checks++;
        if (rf_wdata !== 64'hFFFF_FFFF_FFFF_FFFF || {done, rf_we} !== 2'b11) begin
            errors++;
            $display("FAIL movn_x got wd=%h done=%b we=%b exp ffffffffffffffff 1 1", rf_wdata, done, rf_we);
        end
        issue({9'b000100101, 2'b00, 16'h0000, 5'd1});
        @(negedge clock);
        checks++;
        if (rf_wdata !== 64'h0000_0000_FFFF_FFFF || {done, rf_we} !== 2'b11) begin
            errors++;
            $display("FAIL movn_w got wd=%h done=%b we=%b exp 00000000ffffffff 1 1", rf_wdata, done, rf_we);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] words [2];
        words[0] = {9'b010100101, 2'b10, 16'h4321, 5'd4};
        words[1] = {9'b101100101, 2'b00, 16'h4321, 5'd4};
        for (int i = 0; i < 2; i++) begin
            issue(words[i]);
            @(negedge clock);
            checks++;
            if ({busy, done, illegal, rf_we} !== 4'b1110) begin
                errors++;
                $display("FAIL illegal_fault i=%0d got %b exp 1110", i, {busy, done, illegal, rf_we});
            end
            @(negedge clock);
            checks++;
            if ({busy, done, illegal} !== 3'b000) begin
                errors++;
                $display("FAIL illegal_idle i=%0d got %b exp 000", i, {busy, done, illegal});
            end
        end
    endtask

    task automatic test_back_to_back();
        regs[31] = 64'h5555_6666_7777_8888;
        @(negedge clock);
        start = 1'b1;
        instr = {9'b111100101, 2'b00, 16'hA5A5, 5'd31};
        @(posedge clock);
        #1;
        instr = {9'b110100101, 2'b10, 16'h00FF, 5'd7};
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || rf_sel_a !== 5'd31) begin
            errors++;
            $display("FAIL b2b_read got busy=%b sel=%0d exp 1 31", busy, rf_sel_a);
        end
        @(negedge clock);
        checks++;
        if ({busy, done, rf_we} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_zr_write got %b exp 110", {busy, done, rf_we});
        end
        @(negedge clock);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_gap got %b exp 00", {busy, done});
        end
        @(negedge clock);
        checks++;
        if ({done, rf_we, rf_waddr} !== {2'b11, 5'd7} || rf_wdata !== 64'h0000_00FF_0000_0000) begin
            errors++;
            $display("FAIL b2b_second got ctl=%b addr=%0d wd=%h exp 11 7 000000ff00000000",
                     {done, rf_we}, rf_waddr, rf_wdata);
        end
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        seen = 0;
        regs[2] = 64'h0123_4567_89AB_CDEF;
        issue({9'b111100101, 2'b01, 16'h1357, 5'd2});
        @(negedge clock);
        checks++;
        if (rf_sel_a !== 5'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_read got sel=%0d busy=%b exp 2 1", rf_sel_a, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, rf_we, rf_sel_a} !== 8'h0 || k_out !== 64'h0 || rf_wdata !== 64'h0) begin
            errors++;
            $display("FAIL abort_clear got busy=%b done=%b we=%b sel=%0d k=%h exp zero",
                     busy, done, rf_we, rf_sel_a, k_out);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (done || rf_we || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d active cycles exp 0", seen);
        end
        issue({9'b110100101, 2'b00, 16'hCAFE, 5'd9});
        @(negedge clock);
        checks++;
        if ({done, rf_we, rf_waddr} !== {2'b11, 5'd9} || rf_wdata !== 64'h0000_0000_0000_CAFE) begin
            errors++;
            $display("FAIL abort_next got ctl=%b addr=%0d wd=%h exp 11 9 cafe", {done, rf_we}, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [4:0]  rd;
        logic [63:0] k, res;
        bit          ill, mk;
        for (int i = 0; i < 60; i++) begin
            w = $urandom;
            if ($urandom_range(0, 7) != 0) w[28:23] = 6'b100101;
            rd = w[4:0];
            regs[rd] = {$urandom, $urandom};
            model(w, regs[rd], ill, mk, k, res);
            issue(w);
            @(negedge clock);
            if (ill) begin
                checks++;
                if ({busy, done, illegal, rf_we} !== 4'b1110) begin
                    errors++;
                    $display("FAIL rand_fault i=%0d w=%h got %b exp 1110", i, w, {busy, done, illegal, rf_we});
                end
            end else begin
                if (mk) begin
                    checks++;
                    if ({busy, done, rf_we, rf_sel_a} !== {3'b100, rd}) begin
                        errors++;
                        $display("FAIL rand_read i=%0d w=%h got %b sel=%0d exp 100 sel=%0d",
                                 i, w, {busy, done, rf_we}, rf_sel_a, rd);
                    end
                    @(negedge clock);
                end
                checks++;
                if ({busy, done, illegal, rf_we, rf_waddr} !== {3'b110, (rd != 5'd31), rd} ||
                    rf_wdata !== res) begin
                    errors++;
                    $display("FAIL rand_write i=%0d w=%h got we=%b addr=%0d wd=%h exp we=%b addr=%0d wd=%h",
                             i, w, rf_we, rf_waddr, rf_wdata, (rd != 5'd31), rd, res);
                end
                checks++;
                if (k_out !== k) begin
                    errors++;
                    $display("FAIL rand_k i=%0d w=%h got %h exp %h", i, w, k_out, k);
                end
                if (rd != 5'd31) regs[rd] = res;
            end
            @(negedge clock);
            checks++;
            if ({busy, done, illegal, rf_we, rf_sel_a, rf_waddr} !== 14'h0 ||
                rf_wdata !== 64'h0 || k_out !== 64'h0) begin
                errors++;
                $display("FAIL rand_idle i=%0d got busy=%b done=%b wd=%h k=%h exp zero",
                         i, busy, done, rf_wdata, k_out);
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        instr = 32'h0;
        for (int i = 0; i < 32; i++) regs[i] = 64'h0;
        #3;
        test_reset();
        test_movz();
        test_movk();
        test_movn();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
